// File: rtl/fifo_record_arbiter.sv
// rtl/fifo_record_arbiter.sv - round-robin record arbiter serialising source records onto one FIFO write port
//
// Purpose: grants NSRC record sources in round-robin order and writes the
// granted header byte followed by up to MAXB payload bytes into a byte FIFO,
// stalling on busy without dropping or repeating bytes.
//
// Ports:
//   clk, rst_n   FIFO write clock, asynchronous active-low reset
//   en           grant enable (gates new grants only)
//   req          per-source level request, held until ack
//   hdr/len/payload  per-source record contents, stable while req is high
//   busy         FIFO back-pressure; no write follows an edge where it is high
//   data/write   registered FIFO byte and write strobe
//   ack          one-cycle one-hot pulse when a source's record is written
//   active       high while a record is in progress
//   rec_cnt      wrapping count of completed records
module fifo_record_arbiter #(
  parameter int NSRC = 4,
  parameter int MAXB = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NSRC-1:0]          req,
  input  logic [8*NSRC-1:0]        hdr,
  input  logic [4*NSRC-1:0]        len,
  input  logic [8*MAXB*NSRC-1:0]   payload,
  input  logic                     busy,
  output logic [7:0]               data,
  output logic                     write,
  output logic [NSRC-1:0]          ack,
  output logic                     active,
  output logic [15:0]              rec_cnt
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      k_q, k_d;
  logic [7:0]      data_q, data_d;
  logic            write_q, write_d;
  logic [NSRC-1:0] ack_q, ack_d;
  logic [15:0]     rec_cnt_q, rec_cnt_d;

  logic [NSRC-1:0] req_eff;
  logic            found;
  logic [IW-1:0]   pick;
  logic [3:0]      pick_len_raw;
  logic [3:0]      pick_len;
  logic [7:0]      hdr_sel;
  logic [7:0]      pay_sel;
  int              k_idx;

  // A source being acked this cycle still shows req high on this edge (it
  // drops req on the edge where it sees ack), so it must not be re-granted.
  assign req_eff = req & ~ack_q;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 1; j <= NSRC; j++) begin
      int idx;
      idx = (int'(ptr_q) + j) % NSRC;
      if (!found && req_eff[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign pick_len_raw = len[4*int'(pick) +: 4];
  assign pick_len     = (int'(pick_len_raw) > MAXB) ? 4'(MAXB) : pick_len_raw;
  assign hdr_sel      = hdr[8*int'(gnt_q) +: 8];
  // k_q reaches L only after the last byte; keep the select in range anyway.
  assign k_idx        = (int'(k_q) < MAXB) ? int'(k_q) : 0;
  assign pay_sel      = payload[8*(MAXB*int'(gnt_q) + k_idx) +: 8];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    k_d       = k_q;
    data_d    = data_q;
    write_d   = 1'b0;
    ack_d     = '0;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          gnt_d   = pick;
          ptr_d   = pick;
          len_d   = pick_len;
          k_d     = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (!busy) begin
          data_d  = hdr_sel;
          write_d = 1'b1;
          k_d     = '0;
          state_d = (len_q == 4'd0) ? DONE : PAY;
        end
      end
      PAY: begin
        if (!busy) begin
          data_d  = pay_sel;
          write_d = 1'b1;
          k_d     = k_q + 4'd1;
          if (k_q == len_q - 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        ack_d[gnt_q] = 1'b1;
        rec_cnt_d    = rec_cnt_q + 16'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= IW'(NSRC - 1);
      len_q     <= '0;
      k_q       <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      ack_q     <= '0;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      k_q       <= k_d;
      data_q    <= data_d;
      write_q   <= write_d;
      ack_q     <= ack_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  assign data    = data_q;
  assign write   = write_q;
  assign ack     = ack_q;
  assign active  = (state_q != IDLE);
  assign rec_cnt = rec_cnt_q;

endmodule

// File: doc/fifo_record_arbiter.md
Name: fifo_record_arbiter

Overview:
- Shares the single 8-bit FIFO write port between NSRC record sources: trigger, cycle, and future status/TDC sources.
- Each source raises a request with a header byte, a payload length and a packed payload. The block grants sources round-robin and serialises header plus payload bytes into the FIFO.
- FIFO back-pressure stalls the block without losing data. Source i is acknowledged once its record has been fully written.
- Sits between the per-source record formatters and the readout FIFO, on the FIFO write clock.

Parameters:
NSRC, 4, number of requesting sources (2..8)
MAXB, 6, maximum payload bytes per record (1..15)

Ports:
clk  in  1  FIFO write clock
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; low = finish current record, issue no new grants
req  in  NSRC  per-source record request, level, held until ack
hdr  in  8*NSRC  header byte of source i at [8i+7:8i]
len  in  4*NSRC  payload byte count of source i at [4i+3:4i]
payload  in  8*MAXB*NSRC  payload of source i; byte k at [8*(MAXB*i+k)+7 : 8*(MAXB*i+k)], byte 0 sent first
busy  in  1  FIFO full/almost-full; no write may be issued while sampled high
data  out  8  byte to FIFO, registered
write  out  1  write strobe, registered, one per byte
ack  out  NSRC  one-hot, one-cycle pulse: record of source i fully written
active  out  1  high while a record is in progress (states HDR, PAY, DONE)
rec_cnt  out  16  records completed since reset, wraps 0xFFFF -> 0

Behaviour:
- Reset (async, rst_n low): data=0, write=0, ack=0, active=0, rec_cnt=0, state=IDLE, round-robin pointer=NSRC-1. Reset mid-record abandons the record with no further writes and no ack.
- All inputs are sampled on posedge clk.
- A source keeps hdr/len/payload stable from req rise until the cycle it samples ack high. On that edge it drops req.
- IDLE:
  - If en=1 and any req is set, grant the first requester searching from pointer+1 upward, modulo NSRC.
  - Latch the granted index g and L = min(len[g], MAXB). Update pointer to g. Go to HDR.
  - Otherwise stay in IDLE.
  - write=0 in IDLE.
- HDR:
  - If busy=0: data<=hdr[g], write<=1. If L=0 go to DONE, else go to PAY with k=0.
  - If busy=1: write<=0, hold.
- PAY:
  - If busy=0: data<=payload byte k of g, write<=1, k<=k+1. After byte L-1 go to DONE.
  - If busy=1: write<=0, hold k. A stall may occur between any two bytes of a record.
- DONE: write<=0, ack[g]<=1 for one cycle, rec_cnt<=rec_cnt+1, go to IDLE.
- Records are never interleaved. A record of L payload bytes produces exactly L+1 write pulses.
- With busy=0 throughout, a record takes L+1 write cycles plus DONE plus IDLE: L+3 clocks per record back-to-back.
- data holds its last value when write=0.
- en falling mid-record does not abort: the record completes and is acked. Only IDLE grants are gated by en.
- req dropping mid-record is a source protocol violation. The block ignores req after grant and completes using the current hdr/len/payload values.
- len > MAXB is clamped to MAXB.
- With all sources requesting continuously, service order is pointer+1, pointer+2, …; no source waits more than NSRC-1 records.
- busy is only a gating input; the block issues no write in any cycle following a clock edge where busy was sampled high.

Test Plan:
1. Single source 0 (hdr=0xFF, len=3, payload bytes 0x11,0x22,0x33), busy=0 → data/write sequence FF,11,22,33 on 4 consecutive clocks; ack[0] pulses on the next clock; rec_cnt=1.
2. Sources 0 and 2 request together after reset (pointer=3) → source 0 served first, then source 2. Repeated with 1 and 2 both held high → alternating grants 1,2,1,2.
3. busy driven high for 5 clocks after the second payload byte of a len=4 record → write=0 for those 5 cycles, no byte lost or repeated, total 5 writes, single ack.
4. len=0 with hdr=0xBF → exactly one write of 0xBF, then ack. len=15 with MAXB=6 → 1+6 writes.
5. rst_n pulsed low during PAY → write and ack drop immediately (asynchronously), rec_cnt=0, next request restarts from header.
6. en=0 while a record is in PAY → record completes and is acked; a pending request is not granted until en=1. Force rec_cnt to 0xFFFF, complete one record → rec_cnt=0.
